// File: rtl/sc_vel_multi_if.sv
// -----------------------------------------------------------------------------
// sc_vel_multi_if
// Control/tick bundle for the multi-channel speed-tick generator.
//   SC_VELM_HAB_IN   global enable (0 freezes prescaler and channels)
//   SC_VELM_CLEAR    synchronous clear of prescaler and channel counters
//   SC_VELM_CH_EN    per-channel run enable
//   SC_VELM_WR_EN    period write strobe
//   SC_VELM_WR_ADDR  channel index of the write
//   SC_VELM_WR_DATA  new period (0 = channel off)
//   SC_VELM_TICK     registered one-clock tick per channel (generator output)
//   SC_VELM_LEVEL    speed-up shift, present only with SC_VELM_LEVEL_SPEEDUP_EN
// master = game logic side, slave = generator side.
// -----------------------------------------------------------------------------
interface sc_vel_multi_if #(
    parameter int NUM_CH        = 4,
    parameter int ADDR_WIDTH    = 2,
    parameter int VEL_DATAWIDTH = 8
);
    logic                     SC_VELM_HAB_IN;
    logic                     SC_VELM_CLEAR;
    logic [NUM_CH-1:0]        SC_VELM_CH_EN;
    logic                     SC_VELM_WR_EN;
    logic [ADDR_WIDTH-1:0]    SC_VELM_WR_ADDR;
    logic [VEL_DATAWIDTH-1:0] SC_VELM_WR_DATA;
    logic [NUM_CH-1:0]        SC_VELM_TICK;
`ifdef SC_VELM_LEVEL_SPEEDUP_EN
    logic [1:0]               SC_VELM_LEVEL;

    modport master (
        output SC_VELM_HAB_IN, SC_VELM_CLEAR, SC_VELM_CH_EN,
               SC_VELM_WR_EN, SC_VELM_WR_ADDR, SC_VELM_WR_DATA, SC_VELM_LEVEL,
        input  SC_VELM_TICK
    );
    modport slave (
        input  SC_VELM_HAB_IN, SC_VELM_CLEAR, SC_VELM_CH_EN,
               SC_VELM_WR_EN, SC_VELM_WR_ADDR, SC_VELM_WR_DATA, SC_VELM_LEVEL,
        output SC_VELM_TICK
    );
`else
    modport master (
        output SC_VELM_HAB_IN, SC_VELM_CLEAR, SC_VELM_CH_EN,
               SC_VELM_WR_EN, SC_VELM_WR_ADDR, SC_VELM_WR_DATA,
        input  SC_VELM_TICK
    );
    modport slave (
        input  SC_VELM_HAB_IN, SC_VELM_CLEAR, SC_VELM_CH_EN,
               SC_VELM_WR_EN, SC_VELM_WR_ADDR, SC_VELM_WR_DATA,
        output SC_VELM_TICK
    );
`endif
endinterface

// File: rtl/sc_vel_multi.sv
// -----------------------------------------------------------------------------
// sc_vel_multi
// Multi-channel, run-time programmable speed-tick generator for the lanes.
// A shared prescaler turns SC_VELM_CLOCK_50 into a base strobe; each channel
// counts strobes and emits a registered one-clock tick every PERIOD[i] strobes.
// Ports:
//   SC_VELM_CLOCK_50  system clock
//   SC_VELM_RESET     asynchronous, active-high reset
//   bus               sc_vel_multi_if.slave (enables, clear, write port, ticks)
// Optional feature: define SC_VELM_LEVEL_SPEEDUP_EN to add SC_VELM_LEVEL;
// the reload then becomes max(PER >> LEVEL, 1) - 1.
// The interface instance must use the same NUM_CH/ADDR_WIDTH/VEL_DATAWIDTH.
// -----------------------------------------------------------------------------
module sc_vel_multi #(
    parameter int NUM_CH         = 4,
    parameter int ADDR_WIDTH     = 2,
    parameter int VEL_DATAWIDTH  = 8,
    parameter int PRESC_WIDTH    = 16,
    parameter int PRESC_DIV      = 50000,
    parameter int DEFAULT_PERIOD = 3
) (
    input logic          SC_VELM_CLOCK_50,
    input logic          SC_VELM_RESET,
    sc_vel_multi_if.slave bus
);
    localparam logic [PRESC_WIDTH-1:0]   PRESC_LAST = PRESC_WIDTH'(PRESC_DIV - 1);
    localparam logic [VEL_DATAWIDTH-1:0] ONE        = VEL_DATAWIDTH'(1);
    localparam logic [VEL_DATAWIDTH-1:0] PER_RESET  = VEL_DATAWIDTH'(DEFAULT_PERIOD);

    logic [PRESC_WIDTH-1:0]   presc;
    logic                     strobe;
    logic [VEL_DATAWIDTH-1:0] per    [NUM_CH];
    logic [VEL_DATAWIDTH-1:0] cnt    [NUM_CH];
    logic [VEL_DATAWIDTH-1:0] reload [NUM_CH];
    logic [NUM_CH-1:0]        tick;

    // Strobe only exists while enabled; a frozen prescaler sitting on the
    // last value must not keep firing.
    assign strobe = bus.SC_VELM_HAB_IN && (presc == PRESC_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain updates within an edge.
    always_ff @(posedge SC_VELM_CLOCK_50 or posedge SC_VELM_RESET) begin
        if (SC_VELM_RESET) begin
            presc <= '0;
        end else if (bus.SC_VELM_CLEAR) begin
            presc <= '0;
        end else if (bus.SC_VELM_HAB_IN) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + PRESC_WIDTH'(1);
        end
    end

    // Reload value per channel, computed from the period currently held, so a
    // write landing on the same edge as a reload only affects the next one.
    // NOTE: every always_comb output gets a value on every path (here the
    // loop covers all entries unconditionally), so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef SC_VELM_LEVEL_SPEEDUP_EN
            reload[i] = per[i] >> bus.SC_VELM_LEVEL;
            if (reload[i] == '0) begin
                reload[i] = ONE;
            end
            reload[i] = reload[i] - ONE;
`else
            reload[i] = per[i] - ONE;
`endif
        end
    end

    // NOTE: the period file is small and must come up at DEFAULT_PERIOD, so it
    // is reset like ordinary flops rather than left as an uninitialised memory.
    always_ff @(posedge SC_VELM_CLOCK_50 or posedge SC_VELM_RESET) begin
        if (SC_VELM_RESET) begin
            tick <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                per[i] <= PER_RESET;
                cnt[i] <= '0;
            end
        end else begin
            tick <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                // Out-of-range addresses match no channel and are dropped.
                if (bus.SC_VELM_WR_EN && (bus.SC_VELM_WR_ADDR == ADDR_WIDTH'(i))) begin
                    per[i] <= bus.SC_VELM_WR_DATA;
                end
                if (bus.SC_VELM_CLEAR || (per[i] == '0)) begin
                    // Clear re-phases; period 0 parks the counter at 0 so the
                    // channel ticks on the first strobe after it is re-armed.
                    cnt[i] <= '0;
                end else if (strobe && bus.SC_VELM_CH_EN[i]) begin
                    if (cnt[i] == '0) begin
                        tick[i] <= 1'b1;
                        cnt[i]  <= reload[i];
                    end else begin
                        cnt[i] <= cnt[i] - ONE;
                    end
                end
            end
        end
    end

    assign bus.SC_VELM_TICK = tick;

endmodule
